// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned XLEN_MAX = 64;
  localparam logic [XLEN_MAX-1:0] DIV0_QUOT_MAX = '1;
  localparam logic [XLEN_MAX-1:0] MOST_NEG_MAX  = {1'b1, {(XLEN_MAX-1){1'b0}}};

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } muldiv_state_e;

  function automatic logic op_a_signed(muldiv_op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_b_signed(muldiv_op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_is_rem(muldiv_op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/muldiv_divider.sv
// Unsigned restoring divider datapath: one quotient bit per step.
module muldiv_divider #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_i,
  input  logic            step_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            last_o,
  output logic [XLEN-1:0] quot_nxt_o,
  output logic [XLEN-1:0] rem_nxt_o
);

  localparam int unsigned CW = $clog2(XLEN) + 1;

  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quot_q;
  logic [XLEN-1:0] dvsr_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   trial;

  // Quotient register doubles as the dividend shifter; outputs are post-step values.
  always_comb begin
    shifted = {rem_q, quot_q[XLEN-1]};
    trial   = shifted - {1'b0, dvsr_q};
    if (trial[XLEN]) begin
      rem_nxt_o  = shifted[XLEN-1:0];
      quot_nxt_o = {quot_q[XLEN-2:0], 1'b0};
    end else begin
      rem_nxt_o  = trial[XLEN-1:0];
      quot_nxt_o = {quot_q[XLEN-2:0], 1'b1};
    end
  end

  assign last_o = (cnt_q == CW'(XLEN - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q  <= '0;
      quot_q <= '0;
      dvsr_q <= '0;
      cnt_q  <= '0;
    end else if (load_i) begin
      rem_q  <= '0;
      quot_q <= dividend_i;
      dvsr_q <= divisor_i;
      cnt_q  <= '0;
    end else if (step_i) begin
      rem_q  <= rem_nxt_o;
      quot_q <= quot_nxt_o;
      if (cnt_q != CW'(XLEN)) begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with stall/done handshake to the core.
// MULDIV_FAST_MUL_EN selects a single-cycle combinational multiplier.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] DIV0_QUOT = DIV0_QUOT_MAX[XLEN-1:0];
  localparam logic [XLEN-1:0] MOST_NEG  = MOST_NEG_MAX[XLEN_MAX-1 -: XLEN];

  muldiv_state_e   state_q;
  muldiv_op_e      op_q;
  logic            neg_q;
  logic            done_q;
  logic [XLEN-1:0] result_q;

  muldiv_op_e      op_in;
  logic            a_neg;
  logic            b_neg;
  logic            neg_in;
  logic            is_div_in;
  logic            div_zero;
  logic            div_ovf;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic [XLEN-1:0] fast_div_res;

  // Operand decode, only meaningful in the accepting IDLE cycle.
  assign op_in     = muldiv_op_e'(funct3);
  assign is_div_in = funct3[2];
  assign a_neg     = op_a_signed(op_in) & op_a[XLEN-1];
  assign b_neg     = op_b_signed(op_in) & op_b[XLEN-1];
  assign mag_a     = a_neg ? -op_a : op_a;
  assign mag_b     = b_neg ? -op_b : op_b;
  assign neg_in    = (is_div_in && op_is_rem(op_in)) ? a_neg : (a_neg ^ b_neg);
  assign div_zero  = (op_b == '0);
  assign div_ovf   = op_b_signed(op_in) && (op_a == MOST_NEG) && (op_b == '1);
  assign fast_div_res = div_zero ? (op_is_rem(op_in) ? op_a : DIV0_QUOT)
                                 : (op_is_rem(op_in) ? '0   : MOST_NEG);

  logic            div_load;
  logic            div_step;
  logic            div_last;
  logic [XLEN-1:0] quot_nxt;
  logic [XLEN-1:0] rem_nxt;
  logic [XLEN-1:0] quot_fix;
  logic [XLEN-1:0] rem_fix;
  logic [XLEN-1:0] div_res;

  assign div_load = (state_q == IDLE) && start && is_div_in && !div_zero && !div_ovf;
  assign div_step = (state_q == DIV) && start;

  muldiv_divider #(
    .XLEN(XLEN)
  ) u_divider (
    .clk        (clk),
    .reset      (reset),
    .load_i     (div_load),
    .step_i     (div_step),
    .dividend_i (mag_a),
    .divisor_i  (mag_b),
    .last_o     (div_last),
    .quot_nxt_o (quot_nxt),
    .rem_nxt_o  (rem_nxt)
  );

  assign quot_fix = neg_q ? -quot_nxt : quot_nxt;
  assign rem_fix  = neg_q ? -rem_nxt  : rem_nxt;
  assign div_res  = op_is_rem(op_q) ? rem_fix : quot_fix;

`ifdef MULDIV_FAST_MUL_EN
  logic signed [XLEN:0]   ext_a;
  logic signed [XLEN:0]   ext_b;
  logic [2*XLEN-1:0]      fast_prod;
  logic [XLEN-1:0]        mul_res_in;

  assign ext_a      = {op_a_signed(op_in) & op_a[XLEN-1], op_a};
  assign ext_b      = {op_b_signed(op_in) & op_b[XLEN-1], op_b};
  assign fast_prod  = (2*XLEN)'(ext_a) * (2*XLEN)'(ext_b);
  assign mul_res_in = (op_in == OP_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
`else
  logic [XLEN-1:0]   mcand_q;
  logic [2*XLEN-1:0] prod_q;
  logic [CW-1:0]     mul_cnt_q;
  logic [XLEN:0]     psum;
  logic [2*XLEN-1:0] prod_nxt;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   mul_res;

  // Shift-add on magnitudes: low half starts as the multiplier and shifts out LSB-first.
  assign psum     = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign prod_nxt = {psum, prod_q[XLEN-1:1]};
  assign prod_fix = neg_q ? -prod_nxt : prod_nxt;
  assign mul_res  = (op_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= OP_MUL;
      neg_q    <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
`ifndef MULDIV_FAST_MUL_EN
      mcand_q   <= '0;
      prod_q    <= '0;
      mul_cnt_q <= '0;
`endif
    end else begin
      done_q   <= 1'b0;
      result_q <= '0;
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q  <= op_in;
            neg_q <= neg_in;
            if (!is_div_in) begin
`ifdef MULDIV_FAST_MUL_EN
              state_q  <= DONE;
              done_q   <= 1'b1;
              result_q <= mul_res_in;
`else
              state_q   <= MUL;
              mcand_q   <= mag_a;
              prod_q    <= {{XLEN{1'b0}}, mag_b};
              mul_cnt_q <= '0;
`endif
            end else if (div_zero || div_ovf) begin
              state_q  <= DONE;
              done_q   <= 1'b1;
              result_q <= fast_div_res;
            end else begin
              state_q <= DIV;
            end
          end
        end
`ifndef MULDIV_FAST_MUL_EN
        MUL: begin
          if (!start) begin
            state_q <= IDLE;
          end else begin
            prod_q <= prod_nxt;
            if (mul_cnt_q != CW'(XLEN)) begin
              mul_cnt_q <= mul_cnt_q + CW'(1);
            end
            if (mul_cnt_q == CW'(XLEN - 1)) begin
              state_q  <= DONE;
              done_q   <= 1'b1;
              result_q <= mul_res;
            end
          end
        end
`endif
        DIV: begin
          if (!start) begin
            state_q <= IDLE;
          end else if (div_last) begin
            state_q  <= DONE;
            done_q   <= 1'b1;
            result_q <= div_res;
          end
        end
        DONE: begin
          // start is still high here for the committing instruction; never re-accept.
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign stall  = start & ~done_q;
  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule
